// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 Hz timing constants, sync polarity and the Game-of-Life
// display window, plus small helpers used by the timing generator and renderer.
package vga_timing_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FRONT  = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BACK   = 48;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FRONT  = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BACK   = 33;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    // TinyVGA PMOD expects negative-going sync pulses.
    localparam bit VGA_SYNC_ACTIVE_LOW = 1'b1;

    // Game-of-Life grid window: 64x48 cells of 8x8 pixels, centred on screen.
    localparam int FRAME_CELL_PX = 8;
    localparam int FRAME_COLS    = 64;
    localparam int FRAME_ROWS    = 48;
    localparam int FRAME_W       = FRAME_COLS * FRAME_CELL_PX;
    localparam int FRAME_H       = FRAME_ROWS * FRAME_CELL_PX;
    localparam int FRAME_X0      = (VGA_H_ACTIVE - FRAME_W) / 2;
    localparam int FRAME_Y0      = (VGA_V_ACTIVE - FRAME_H) / 2;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic display_on;
        logic line_start;
        logic frame_start;
        logic vblank_start;
    } vga_flags_t;

    function automatic logic in_span(input logic [9:0] v, input int first, input int len);
        return (int'(v) >= first) && (int'(v) < first + len);
    endfunction

    function automatic logic in_frame_window(input logic [9:0] h, input logic [9:0] v);
        return in_span(h, FRAME_X0, FRAME_W) && in_span(v, FRAME_Y0, FRAME_H);
    endfunction

endpackage

// File: rtl/vga_wrap_counter.sv
// Modulo-N up-counter with increment enable; wrap is high in the cycle the
// counter steps from MODULUS-1 back to zero.
module vga_wrap_counter #(
    parameter int WIDTH   = 10,
    parameter int MODULUS = 800
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] value,
    output logic             wrap
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        value_d = value_q;
        wrap    = inc && (value_q == WIDTH'(MODULUS - 1));
        if (wrap) begin
            value_d = '0;
        end else if (inc) begin
            value_d = value_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel coordinates, syncs, active-video flag and
// frame-aligned strobes, all registered and aligned with hpos/vpos.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE        = VGA_H_ACTIVE,
    parameter int H_FRONT         = VGA_H_FRONT,
    parameter int H_SYNC          = VGA_H_SYNC,
    parameter int H_BACK          = VGA_H_BACK,
    parameter int V_ACTIVE        = VGA_V_ACTIVE,
    parameter int V_FRONT         = VGA_V_FRONT,
    parameter int V_SYNC          = VGA_V_SYNC,
    parameter int V_BACK          = VGA_V_BACK,
    parameter bit SYNC_ACTIVE_LOW = VGA_SYNC_ACTIVE_LOW,
    parameter int FCOUNT_W        = 8,
    parameter int UPDATE_FRAMES   = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    output logic [9:0]          hpos,
    output logic [9:0]          vpos,
    output logic                hsync,
    output logic                vsync,
    output logic                display_on,
    output logic                line_start,
    output logic                frame_start,
    output logic                vblank_start,
    output logic                update_tick,
    output logic [FCOUNT_W-1:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic       SYNC_ON    = SYNC_ACTIVE_LOW ? 1'b0 : 1'b1;
    localparam vga_flags_t FLAGS_IDLE = '{hsync: ~SYNC_ON, vsync: ~SYNC_ON, default: 1'b0};

    logic                started_q;
    logic                h_wrap;
    logic                v_wrap;
    logic                div_inc;
    logic                div_wrap;
    logic [7:0]          div_value_unused;
    logic [9:0]          h_next;
    logic [9:0]          v_next;
    vga_flags_t          flags_d;
    vga_flags_t          flags_q;
    logic                update_tick_d;
    logic                update_tick_q;
    logic [FCOUNT_W-1:0] frame_count_d;
    logic [FCOUNT_W-1:0] frame_count_q;

    // hpos holds at 0 for the first cycle after reset, then free-runs.
    vga_wrap_counter #(.WIDTH(10), .MODULUS(H_TOTAL)) u_hcount (
        .clk   (clk),
        .reset (reset),
        .inc   (started_q),
        .value (hpos),
        .wrap  (h_wrap)
    );

    vga_wrap_counter #(.WIDTH(10), .MODULUS(V_TOTAL)) u_vcount (
        .clk   (clk),
        .reset (reset),
        .inc   (h_wrap),
        .value (vpos),
        .wrap  (v_wrap)
    );

    // The frame divider is only observed through its wrap pulse.
    vga_wrap_counter #(.WIDTH(8), .MODULUS(UPDATE_FRAMES)) u_frame_div (
        .clk   (clk),
        .reset (reset),
        .inc   (div_inc),
        .value (div_value_unused),
        .wrap  (div_wrap)
    );

    // Flags are decoded from the coordinates the counters load on this edge,
    // so the registered flags line up with hpos/vpos with no latency.
    always_comb begin
        h_next = hpos;
        v_next = vpos;
        if (h_wrap) begin
            h_next = '0;
        end else if (started_q) begin
            h_next = hpos + 10'd1;
        end
        if (v_wrap) begin
            v_next = '0;
        end else if (h_wrap) begin
            v_next = vpos + 10'd1;
        end

        flags_d              = '0;
        flags_d.hsync        = in_span(h_next, H_ACTIVE + H_FRONT, H_SYNC) ? SYNC_ON : ~SYNC_ON;
        flags_d.vsync        = in_span(v_next, V_ACTIVE + V_FRONT, V_SYNC) ? SYNC_ON : ~SYNC_ON;
        flags_d.display_on   = (h_next < 10'(H_ACTIVE)) && (v_next < 10'(V_ACTIVE));
        flags_d.line_start   = (h_next == '0);
        flags_d.frame_start  = (h_next == '0) && (v_next == '0);
        flags_d.vblank_start = (h_next == '0) && (v_next == 10'(V_ACTIVE));

        frame_count_d = v_wrap ? frame_count_q + FCOUNT_W'(1) : frame_count_q;
    end

    assign div_inc       = run && flags_d.vblank_start;
    assign update_tick_d = div_wrap;

    always_ff @(posedge clk) begin
        if (reset) begin
            started_q     <= 1'b0;
            flags_q       <= FLAGS_IDLE;
            update_tick_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            started_q     <= 1'b1;
            flags_q       <= flags_d;
            update_tick_q <= update_tick_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign hsync        = flags_q.hsync;
    assign vsync        = flags_q.vsync;
    assign display_on   = flags_q.display_on;
    assign line_start   = flags_q.line_start;
    assign frame_start  = flags_q.frame_start;
    assign vblank_start = flags_q.vblank_start;
    assign update_tick  = update_tick_q;
    assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 timing for line/reset behaviour, plus two
// reduced-timing instances (UPDATE_FRAMES=3 and 1) for frame-level behaviour.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Instance a: default 640x480 timing.
    logic       reset_a, run_a;
    logic [9:0] hpos_a, vpos_a;
    logic       hsync_a, vsync_a, display_on_a, line_start_a, frame_start_a, vblank_start_a, update_tick_a;
    logic [7:0] frame_count_a;

    vga_timing_gen u_full (
        .clk(clk), .reset(reset_a), .run(run_a),
        .hpos(hpos_a), .vpos(vpos_a), .hsync(hsync_a), .vsync(vsync_a),
        .display_on(display_on_a), .line_start(line_start_a), .frame_start(frame_start_a),
        .vblank_start(vblank_start_a), .update_tick(update_tick_a), .frame_count(frame_count_a)
    );

    // Instances b (UPDATE_FRAMES=3) and c (UPDATE_FRAMES=1): H 8/1/2/1 -> 12, V 4/1/1/1 -> 7, 84 clocks/frame.
    logic       reset_b, run_b;
    logic [9:0] hpos_b, vpos_b, hpos_c, vpos_c;
    logic       hsync_b, vsync_b, display_on_b, line_start_b, frame_start_b, vblank_start_b, update_tick_b;
    logic       hsync_c, vsync_c, display_on_c, line_start_c, frame_start_c, vblank_start_c, update_tick_c;
    logic [7:0] frame_count_b, frame_count_c;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .FCOUNT_W(8), .UPDATE_FRAMES(3)
    ) u_small (
        .clk(clk), .reset(reset_b), .run(run_b),
        .hpos(hpos_b), .vpos(vpos_b), .hsync(hsync_b), .vsync(vsync_b),
        .display_on(display_on_b), .line_start(line_start_b), .frame_start(frame_start_b),
        .vblank_start(vblank_start_b), .update_tick(update_tick_b), .frame_count(frame_count_b)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .FCOUNT_W(8), .UPDATE_FRAMES(1)
    ) u_one (
        .clk(clk), .reset(reset_b), .run(run_b),
        .hpos(hpos_c), .vpos(vpos_c), .hsync(hsync_c), .vsync(vsync_c),
        .display_on(display_on_c), .line_start(line_start_c), .frame_start(frame_start_c),
        .vblank_start(vblank_start_c), .update_tick(update_tick_c), .frame_count(frame_count_c)
    );

    task automatic check_idle_a(input string tag);
        check({tag, "_hpos"}, hpos_a, 0);
        check({tag, "_vpos"}, vpos_a, 0);
        check({tag, "_hsync"}, hsync_a, 1);
        check({tag, "_vsync"}, vsync_a, 1);
        check({tag, "_disp"}, display_on_a, 0);
        check({tag, "_strobes"}, {line_start_a, frame_start_a, vblank_start_a, update_tick_a}, 0);
        check({tag, "_fcount"}, frame_count_a, 0);
    endtask

    task automatic check_idle_b(input string tag);
        check({tag, "_hpos"}, hpos_b, 0);
        check({tag, "_vpos"}, vpos_b, 0);
        check({tag, "_syncs"}, {hsync_b, vsync_b}, 2'b11);
        check({tag, "_disp"}, display_on_b, 0);
        check({tag, "_strobes"}, {line_start_b, frame_start_b, vblank_start_b, update_tick_b}, 0);
        check({tag, "_fcount"}, frame_count_b, 0);
        check({tag, "_tick1"}, update_tick_c, 0);
    endtask

    initial begin
        int hs_low;
        reset_a = 1'b1;
        run_a   = 1'b1;
        reset_b = 1'b1;
        run_b   = 1'b0;
        step();
        step();
        check_idle_a("rst_a");
        check_idle_b("rst_b");

        // Two full lines of default timing after release.
        reset_a = 1'b0;
        hs_low  = 0;
        for (int i = 0; i < 1600; i++) begin
            int h;
            h = i % 800;
            step();
            check("line_hpos", hpos_a, h);
            check("line_vpos", vpos_a, i / 800);
            check("line_start", line_start_a, (h == 0));
            check("line_frame_start", frame_start_a, (i == 0));
            check("line_hsync", hsync_a, !(h >= 656 && h <= 751));
            check("line_disp", display_on_a, (h < 640));
            check("line_vsync", vsync_a, 1);
            check("line_vblank", vblank_start_a, 0);
            check("line_fcount", frame_count_a, 0);
            if (i < 800 && hsync_a == 1'b0) hs_low++;
        end
        check("hsync_low_clocks", hs_low, 96);

        // Mid-frame reset at hpos=300, vpos=2.
        for (int i = 1600; i <= 1900; i++) step();
        check("pre_rst_hpos", hpos_a, 300);
        check("pre_rst_vpos", vpos_a, 2);
        reset_a = 1'b1;
        step();
        check_idle_a("midrst");
        reset_a = 1'b0;
        step();
        check("post_rst_hpos", hpos_a, 0);
        check("post_rst_vpos", vpos_a, 0);
        check("post_rst_fstart", frame_start_a, 1);
        check("post_rst_lstart", line_start_a, 1);
        check("post_rst_disp", display_on_a, 1);
        check("post_rst_fcount", frame_count_a, 0);
        step();
        check("post_rst2_hpos", hpos_a, 1);
        check("post_rst2_fstart", frame_start_a, 0);

        // Seven reduced frames with run=1: ticks on the 3rd and 6th vblank only.
        run_b   = 1'b1;
        reset_b = 1'b0;
        for (int c = 0; c < 7 * 84; c++) begin
            int h, v;
            h = c % 12;
            v = (c % 84) / 12;
            step();
            check("sm_hpos", hpos_b, h);
            check("sm_vpos", vpos_b, v);
            check("sm_hsync", hsync_b, !(h == 9 || h == 10));
            check("sm_vsync", vsync_b, (v != 5));
            check("sm_disp", display_on_b, (h < 8 && v < 4));
            check("sm_lstart", line_start_b, (h == 0));
            check("sm_fstart", frame_start_b, (c % 84 == 0));
            check("sm_vblank", vblank_start_b, (c % 84 == 48));
            check("sm_fcount", frame_count_b, c / 84);
            check("sm_tick3", update_tick_b, (c == 2 * 84 + 48 || c == 5 * 84 + 48));
            check("sm_tick1", update_tick_c, (c % 84 == 48));
        end

        // run=1 for frame 0, low for frames 1-2, high again; also brief drops away from vblank.
        reset_b = 1'b1;
        step();
        check_idle_b("rst_b2");
        reset_b = 1'b0;
        for (int c = 0; c < 5 * 84; c++) begin
            run_b = !((c >= 84 && c < 252) || (c >= 320 && c < 340));
            step();
            check("hold_tick3", update_tick_b, (c == 384));
            check("hold_tick1", update_tick_c, (c == 48 || c == 300 || c == 384));
        end

        // frame_count wrap over 257 reduced frames, run=0 throughout.
        run_b   = 1'b0;
        reset_b = 1'b1;
        step();
        check_idle_b("rst_b3");
        reset_b = 1'b0;
        for (int c = 0; c <= 257 * 84; c++) begin
            step();
            if (c % 84 == 0) begin
                check("fc_fstart", frame_start_b, 1);
                check("fc_value", frame_count_b, (c / 84) % 256);
            end
            if (c % 84 == 48) check("fc_tick_idle", update_tick_c, 0);
            if (c == 255 * 84) check("fc_at_255", frame_count_b, 255);
            if (c == 256 * 84 - 1) check("fc_hold_255", frame_count_b, 255);
            if (c == 256 * 84) check("fc_wrap_0", frame_count_b, 0);
            if (c == 257 * 84) check("fc_after_wrap", frame_count_b, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Synchronous VGA timing generator that sits directly upstream of the Game-of-Life display/simulation top. It produces pixel coordinates, sync pulses and the active-video flag consumed by the renderer. It also produces frame-aligned strobes, so the simulation controller can start updates at vertical blank instead of polling raw vsync against a free-running timer. Default timing is 640x480@60 Hz, driven from the pixel clock.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width (clocks)
H_BACK, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_ACTIVE_LOW, 1, 1 = hsync/vsync pulse low (TinyVGA PMOD)
FCOUNT_W, 8, width of frame_count
UPDATE_FRAMES, 6, vblanks per update_tick (legal range 1..255)

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-high reset
run  in  1  enables update_tick generation (simulation running)
hpos  out  10  current column, 0..H_TOTAL-1
vpos  out  10  current line, 0..V_TOTAL-1
hsync  out  1  horizontal sync, polarity per SYNC_ACTIVE_LOW
vsync  out  1  vertical sync, polarity per SYNC_ACTIVE_LOW
display_on  out  1  high when hpos<H_ACTIVE and vpos<V_ACTIVE
line_start  out  1  1-cycle pulse at hpos==0
frame_start  out  1  1-cycle pulse at hpos==0, vpos==0
vblank_start  out  1  1-cycle pulse at hpos==0, vpos==V_ACTIVE
update_tick  out  1  1-cycle pulse coincident with every UPDATE_FRAMES-th vblank_start while run=1
frame_count  out  FCOUNT_W  frames completed since reset, wraps

Behaviour:
- Derived constants: H_TOTAL = sum of the four H parameters (default 800). V_TOTAL = sum of the four V parameters (default 525).
- One clock; reset is synchronous and active-high; the clock port is clk and the reset port is reset.
- hpos increments every clock. At H_TOTAL-1 it wraps to 0 and vpos increments. At vpos==V_TOTAL-1 with hpos==H_TOTAL-1, both wrap to 0.
- All outputs are registered. Every output is a pure function of the hpos/vpos values presented in the same cycle; there is zero latency between the coordinates and the syncs or flags.
- hsync is asserted for hpos in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1] (default 656..751).
- vsync is asserted for vpos in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC-1] (default 490..491), for whole lines.
- Asserted level is 0 when SYNC_ACTIVE_LOW=1, otherwise 1.
- frame_count increments in the same cycle frame_start is high, excluding the first (0,0) after reset. It wraps modulo 2^FCOUNT_W.
- Frame divider (internal counter, 0..UPDATE_FRAMES-1):
  - Sampled only in vblank_start cycles.
  - If run=1 and the divider equals UPDATE_FRAMES-1: update_tick=1 and the divider goes to 0.
  - If run=1 otherwise: the divider increments.
  - If run=0: the divider holds and update_tick=0.
  - With UPDATE_FRAMES=1, update_tick fires on every vblank_start while run=1.
- While reset=1:
  - hpos=0, vpos=0, frame_count=0, divider=0.
  - hsync and vsync are at their inactive level; display_on=0.
  - All strobes (line_start, frame_start, vblank_start, update_tick) are 0.
- First cycle after reset deasserts:
  - hpos=0, vpos=0, display_on=1.
  - line_start=1 and frame_start=1; frame_count stays 0.
- Reset asserted mid-frame takes effect on the next clock edge regardless of position. No partial sync pulse is extended.
- run toggling outside vblank_start cycles has no effect on the divider.

Decomposition:
- Shared package vga_timing_pkg holds:
  - 640x480 timing localparams (H_/V_ ACTIVE, FRONT, SYNC, BACK).
  - The derived H_TOTAL and V_TOTAL.
  - The TinyVGA sync polarity constant.
  - The display-frame window constants reused by the renderer.
- One sub-module is natural: vga_wrap_counter (parameters: width and modulus; ports: clk, reset, inc enable, value, wrap pulse). It is instantiated three times, for hpos, vpos and the frame divider.

Test Plan:
1. Release reset, run 801 clocks -> hpos steps 0..799 then 0, and vpos changes 0->1 exactly when hpos wraps; line_start pulses at cycles 0 and 800.
2. Observe one full frame -> hsync low only for hpos 656..751 (96 clocks per line); vsync low for exactly 1600 clocks (vpos 490..491); display_on high for exactly 307200 clocks and low at (640,0) and (0,480).
3. UPDATE_FRAMES=3, run=1 for 7 frames -> update_tick on the 3rd and 6th vblank_start only, each exactly 1 cycle wide, coincident with vpos=480, hpos=0.
4. UPDATE_FRAMES=3, run=1 for 1 frame, run=0 for 2 frames, then run=1 -> divider holds at 1, so update_tick occurs on the 2nd vblank_start after run returns high.
5. Reduced timing (H 8/1/2/1, V 4/1/1/1), FCOUNT_W=8, 257 frames -> frame_count reaches 255 then wraps to 0 on the 256th frame_start, then reads 1 on the next.
6. Assert reset for 1 cycle at hpos=300, vpos=200 with run=1 -> next cycle hpos=0, vpos=0, display_on=0, syncs inactive, all strobes 0; the following cycle hpos=0, frame_start=1, frame_count=0.
